rvc_fetch_buffer: RTL and testbench

Parametrised RVC instruction fetch buffer between the I-cache and the decode stage. Fetches 32-bit aligned words into a circular halfword queue, reassembles 16-bit and 32-bit instructions at any halfword boundary (including 32-bit instructions split across words), and presents them one per cycle with a valid/ready handshake. Supports a redirect that flushes the queue, with safe abandonment of an I-cache miss that is still in flight.

---
 rtl/rvc_fetch_buffer_pkg.sv | 22 ++
 rtl/rvc_fetch_buffer_hw_queue.sv | 73 +++++++
 rtl/rvc_fetch_buffer.sv | 174 +++++++++++++++++
 tb/tb_rvc_fetch_buffer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvc_fetch_buffer_pkg.sv
// fetch_pkg: types and constants used by the RVC fetch buffer.
//   halfword_t    : one 16-bit queue entry (a parcel of an instruction)
//   fetch_state_e : fetch FSM states
//   INST_ALIGN    : instruction alignment in bytes (one halfword)
//   byteswap32    : byte reversal of a 32-bit word, used when
//                   FETCH_BYTESWAP_EN is defined
package fetch_pkg;

  typedef logic [15:0] halfword_t;

  typedef enum logic {
    FETCH = 1'b0,  // normal operation
    DROP  = 1'b1   // redirected while a miss is in flight; discard its data
  } fetch_state_e;

  localparam int unsigned INST_ALIGN = 2;

  function automatic logic [31:0] byteswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/rvc_fetch_buffer_hw_queue.sv
// hw_queue: circular queue of DEPTH halfwords.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : empty the queue (wins over writes and pops)
//   wr_cnt        : number of entries written this cycle (0..2)
//   wr_data0/1    : first / second entry written
//   rd_cnt        : number of entries popped this cycle (0..2)
//   h0, h1        : head entry and the entry after it
//   count         : current occupancy
// The caller guarantees no overflow (free space checked before writing)
// and no underflow (pops only what is present).
module hw_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [1:0]    wr_cnt,
  input  logic [15:0]   wr_data0,
  input  logic [15:0]   wr_data1,
  input  logic [1:0]    rd_cnt,
  output logic [15:0]   h0,
  output logic [15:0]   h1,
  output logic [CW-1:0] count
);

  halfword_t         mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    head_d  = head_q + PW'(rd_cnt);
    tail_d  = tail_q + PW'(wr_cnt);
    count_d = count_q + CW'(wr_cnt) - CW'(rd_cnt);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only read once count says it
  // has been written, so resetting it would cost flops for nothing.
  always_ff @(posedge clk) begin
    if (wr_cnt != 2'd0) mem_q[tail_q] <= wr_data0;
    if (wr_cnt == 2'd2) mem_q[tail_q + PW'(1)] <= wr_data1;
  end

  assign h0    = mem_q[head_q];
  assign h1    = mem_q[head_q + PW'(1)];
  assign count = count_q;

endmodule

// File: rtl/rvc_fetch_buffer.sv
// rvc_fetch_buffer: RVC instruction fetch buffer between I-cache and decode.
// Fetches aligned words into a halfword queue and presents reassembled
// 16/32-bit instructions one per cycle with a valid/ready handshake.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   redirect_valid, redirect_pc : flush and restart fetch at redirect_pc
//   inst_valid, inst_ready      : decode handshake
//   inst, inst_pc               : instruction (RVC zero-extended) and its PC
//   inst_compressed             : inst[1:0] != 2'b11
//   ICACHE_ren/addr             : word read request (held while stalled)
//   ICACHE_wen/wdata            : tied to zero
//   ICACHE_rdata/stall          : read data / response-not-ready
// Configuration macro FETCH_BYTESWAP_EN: byte-reverse ICACHE_rdata before
// enqueueing (big-endian memory model); undefined uses it as-is.
module rvc_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_compressed,
  output logic        ICACHE_ren,
  output logic        ICACHE_wen,
  output logic [29:0] ICACHE_addr,
  output logic [31:0] ICACHE_wdata,
  input  logic [31:0] ICACHE_rdata,
  input  logic        ICACHE_stall
);

  localparam int          CW          = $clog2(DEPTH + 1);
  localparam logic [31:0] RESET_PC_HW = {RESET_PC[31:1], 1'b0};

  fetch_state_e state_q, state_d;
  logic         pending_q, pending_d;
  logic [29:0]  held_addr_q, held_addr_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  head_pc_q, head_pc_d;

  logic [CW-1:0] q_count;
  logic [15:0]   h0, h1;
  logic [1:0]    wr_cnt, rd_cnt;
  logic [15:0]   wr_data0, wr_data1;
  logic [31:0]   word;
  logic [31:0]   redir_pc_hw;
  logic          free_ok, resp, resp_en, accept, pop;
  logic          unused_redirect_bit0;

  assign redir_pc_hw          = {redirect_pc[31:1], 1'b0};
  assign unused_redirect_bit0 = redirect_pc[0];

  // ---------------- fetch request ----------------
  assign free_ok      = (DEPTH - int'(q_count)) >= 2;
  assign ICACHE_ren   = !rst && (pending_q || free_ok);
  // A stalled request keeps its address even if a redirect has already
  // moved fetch_pc on.
  assign ICACHE_addr  = pending_q ? held_addr_q : fetch_pc_q[31:2];
  assign ICACHE_wen   = 1'b0;
  assign ICACHE_wdata = '0;

  assign resp   = ICACHE_ren && !ICACHE_stall;
  assign accept = resp && resp_en && !redirect_valid;

`ifdef FETCH_BYTESWAP_EN
  assign word = byteswap32(ICACHE_rdata);
`else
  assign word = ICACHE_rdata;
`endif

  // From a halfword-odd PC only the upper halfword belongs to the stream.
  always_comb begin
    wr_cnt   = 2'd0;
    wr_data0 = fetch_pc_q[1] ? word[31:16] : word[15:0];
    wr_data1 = word[31:16];
    if (accept) wr_cnt = fetch_pc_q[1] ? 2'd1 : 2'd2;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // The redirect may coincide with the cycle that first issues a stalled
  // request, so the test is on the live request, not just pending_q.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (redirect_valid && ICACHE_ren && ICACHE_stall) state_d = DROP;
      DROP:    if (resp) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    resp_en = 1'b0;
    case (state_q)
      FETCH:   resp_en = 1'b1;
      DROP:    resp_en = 1'b0;
      default: resp_en = 1'b0;
    endcase
  end

  // ---------------- output decode ----------------
  always_comb begin
    inst_compressed = (h0[1:0] != 2'b11);
    if (inst_compressed) begin
      inst_valid = (q_count >= CW'(1));
      inst       = {16'b0, h0};
    end else begin
      inst_valid = (q_count >= CW'(2));
      inst       = {h1, h0};
    end
    inst_pc = head_pc_q;
  end

  // Redirect beats a same-cycle dequeue.
  assign pop    = inst_valid && inst_ready && !redirect_valid;
  assign rd_cnt = pop ? (inst_compressed ? 2'd1 : 2'd2) : 2'd0;

  // ---------------- PC / pending bookkeeping ----------------
  always_comb begin
    pending_d   = ICACHE_ren && ICACHE_stall;
    held_addr_d = ICACHE_addr;
    fetch_pc_d  = fetch_pc_q;
    head_pc_d   = head_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redir_pc_hw;
      head_pc_d  = redir_pc_hw;
    end else begin
      if (accept)
        fetch_pc_d = fetch_pc_q + (fetch_pc_q[1] ? INST_ALIGN : 2 * INST_ALIGN);
      if (pop)
        head_pc_d = head_pc_q + (inst_compressed ? INST_ALIGN : 2 * INST_ALIGN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= 1'b0;
      held_addr_q <= '0;
      fetch_pc_q  <= RESET_PC_HW;
      head_pc_q   <= RESET_PC_HW;
    end else begin
      pending_q   <= pending_d;
      held_addr_q <= held_addr_d;
      fetch_pc_q  <= fetch_pc_d;
      head_pc_q   <= head_pc_d;
    end
  end

  hw_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .wr_cnt   (wr_cnt),
    .wr_data0 (wr_data0),
    .wr_data1 (wr_data1),
    .rd_cnt   (rd_cnt),
    .h0       (h0),
    .h1       (h1),
    .count    (q_count)
  );

endmodule

// File: tb/tb_rvc_fetch_buffer.sv
// Self-checking bench for rvc_fetch_buffer. A behavioural model walks the
// program image from the current PC and predicts every instruction the
// consumer accepts; directed steps check reset, latency, alignment,
// miss/redirect, back-pressure and reset mid-operation, followed by a
// randomized run with random stalls, back-pressure, redirects and resets.
module tb_rvc_fetch_buffer;

  localparam int          DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;
  logic        ICACHE_stall = 1'b0;
  logic [31:0] ICACHE_rdata = '0;
  logic        inst_valid, inst_compressed;
  logic [31:0] inst, inst_pc;
  logic        ICACHE_ren, ICACHE_wen;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_wdata;

  rvc_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_compressed (inst_compressed),
    .ICACHE_ren      (ICACHE_ren),
    .ICACHE_wen      (ICACHE_wen),
    .ICACHE_addr     (ICACHE_addr),
    .ICACHE_wdata    (ICACHE_wdata),
    .ICACHE_rdata    (ICACHE_rdata),
    .ICACHE_stall    (ICACHE_stall)
  );

  always #5 clk = ~clk;

  // Program image in program (little-endian) order, 4 KB, wraps.
  logic [31:0] mem [1024];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          n_deq    = 0;
  int          stall_pct = 0;
  int          ready_pct = 100;
  logic [31:0] exp_pc;
  bit          cur_rst, cur_redir;
  logic [31:0] cur_rpc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cache_word(input logic [29:0] addr);
    logic [31:0] w;
    w = mem[addr[9:0]];
`ifdef FETCH_BYTESWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem[pc[11:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  // Reference: the instruction that starts at pc and its length in bytes.
  task automatic ref_inst(input logic [31:0] pc, output logic [31:0] ins, output int len);
    logic [15:0] lo;
    lo = hw_at(pc);
    if (lo[1:0] != 2'b11) begin
      ins = {16'h0000, lo};
      len = 2;
    end else begin
      ins = {hw_at(pc + 32'd2), lo};
      len = 4;
    end
  endtask

  // Drive one cycle's inputs on the falling edge; outputs are then stable.
  task automatic cyc_begin(input bit r = 1'b0, input bit redir = 1'b0,
                           input logic [31:0] rpc = '0);
    @(negedge clk);
    rst            = r;
    redirect_valid = redir;
    redirect_pc    = rpc;
    ICACHE_stall   = ($urandom_range(99) < stall_pct);
    inst_ready     = ($urandom_range(99) < ready_pct);
    ICACHE_rdata   = cache_word(ICACHE_addr);
    cur_rst        = r;
    cur_redir      = redir;
    cur_rpc        = rpc;
    #1;
  endtask

  // Compare any accepted instruction against the model, then advance.
  task automatic cyc_end();
    logic [31:0] ei;
    int          el;
    if (!cur_rst && !cur_redir && inst_valid === 1'b1 && inst_ready) begin
      ref_inst(exp_pc, ei, el);
      check("stream_inst", inst, ei);
      check("stream_pc", inst_pc, exp_pc);
      check("stream_rvc", {31'b0, inst_compressed}, {31'b0, (el == 2)});
      exp_pc = exp_pc + el;
      n_deq++;
    end
    if (cur_rst)        exp_pc = {RESET_PC[31:1], 1'b0};
    else if (cur_redir) exp_pc = {cur_rpc[31:1], 1'b0};
    @(posedge clk);
  endtask

  task automatic step(input bit r = 1'b0, input bit redir = 1'b0,
                      input logic [31:0] rpc = '0);
    cyc_begin(r, redir, rpc);
    cyc_end();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0]    = 32'h0000_0013;
    mem[1]    = 32'h0010_0093;
    mem[32'h40] = 32'h4585_FFFF;   // 0x102 holds c.li; low half must be skipped
    mem[32'h80] = 32'h4505_4501;
    mem[32'h60] = ~mem[32'h80];
    exp_pc    = {RESET_PC[31:1], 1'b0};

    // ---- reset ----
    cyc_begin(1'b1); check("rst_ren", {31'b0, ICACHE_ren}, 0); cyc_end();
    cyc_begin(1'b1);
    check("rst_ren2", {31'b0, ICACHE_ren}, 0);
    check("rst_valid", {31'b0, inst_valid}, 0);
    check("rst_wen", {31'b0, ICACHE_wen}, 0);
    check("rst_wdata", ICACHE_wdata, 0);
    cyc_end();

    // ---- aligned straight-line ----
    cyc_begin();
    check("first_ren", {31'b0, ICACHE_ren}, 1);
    check("first_addr", {2'b0, ICACHE_addr}, {2'b0, RESET_PC[31:2]});
    check("first_valid", {31'b0, inst_valid}, 0);
    cyc_end();
    cyc_begin();
    check("al0_valid", {31'b0, inst_valid}, 1);
    check("al0_inst", inst, 32'h0000_0013);
    check("al0_pc", inst_pc, 32'h0);
    check("al0_rvc", {31'b0, inst_compressed}, 0);
    cyc_end();
    cyc_begin();
    check("al1_valid", {31'b0, inst_valid}, 1);
    check("al1_inst", inst, 32'h0010_0093);
    check("al1_pc", inst_pc, 32'h4);
    cyc_end();

    // ---- mixed RVC, split 32-bit instruction ----
    mem[0] = 32'h0513_4501;
    mem[1] = {mem[1][31:16], 16'h0000};
    step(1'b0, 1'b1, 32'h0);
    cyc_begin();
    check("mx_ren", {31'b0, ICACHE_ren}, 1);
    check("mx_addr", {2'b0, ICACHE_addr}, 32'h0);
    check("mx_valid_t1", {31'b0, inst_valid}, 0);
    cyc_end();
    cyc_begin();
    check("mx0_valid", {31'b0, inst_valid}, 1);
    check("mx0_inst", inst, 32'h0000_4501);
    check("mx0_pc", inst_pc, 32'h0);
    check("mx0_rvc", {31'b0, inst_compressed}, 1);
    cyc_end();
    cyc_begin();
    check("mx1_valid", {31'b0, inst_valid}, 1);
    check("mx1_inst", inst, 32'h0000_0513);
    check("mx1_pc", inst_pc, 32'h2);
    check("mx1_rvc", {31'b0, inst_compressed}, 0);
    cyc_end();

    // ---- unaligned redirect ----
    step(1'b0, 1'b1, 32'h102);
    cyc_begin();
    check("ua_addr0", {2'b0, ICACHE_addr}, 32'h40);
    check("ua_ren0", {31'b0, ICACHE_ren}, 1);
    cyc_end();
    cyc_begin();
    check("ua_addr1", {2'b0, ICACHE_addr}, 32'h41);
    check("ua_valid", {31'b0, inst_valid}, 1);
    check("ua_pc", inst_pc, 32'h102);
    check("ua_inst", inst, 32'h0000_4585);
    cyc_end();

    // ---- back-pressure: aligned fill stops at 8, unaligned at 7 ----
    ready_pct = 0;
    step(1'b0, 1'b1, 32'h140);
    for (int i = 0; i < 4; i++) begin
      cyc_begin(); check("bp8_ren_on", {31'b0, ICACHE_ren}, 1); cyc_end();
    end
    for (int i = 0; i < 2; i++) begin
      cyc_begin();
      check("bp8_ren_off", {31'b0, ICACHE_ren}, 0);
      check("bp8_valid", {31'b0, inst_valid}, 1);
      check("bp8_pc", inst_pc, 32'h140);
      cyc_end();
    end
    step(1'b0, 1'b1, 32'h142);
    for (int i = 0; i < 4; i++) begin
      cyc_begin(); check("bp7_ren_on", {31'b0, ICACHE_ren}, 1); cyc_end();
    end
    cyc_begin();
    check("bp7_ren_off", {31'b0, ICACHE_ren}, 0);
    check("bp7_pc", inst_pc, 32'h142);
    cyc_end();
    ready_pct = 100;
    d0 = n_deq;
    repeat (40) step();
    check("bp_throughput", n_deq - d0, 40);

    // ---- redirect during a miss ----
    step(1'b0, 1'b1, 32'h180);
    stall_pct = 100;
    cyc_begin();
    check("miss_ren_c1", {31'b0, ICACHE_ren}, 1);
    check("miss_addr_c1", {2'b0, ICACHE_addr}, 32'h60);
    cyc_end();
    cyc_begin(1'b0, 1'b1, 32'h200);
    check("miss_addr_c2", {2'b0, ICACHE_addr}, 32'h60);
    cyc_end();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) stall_pct = 0;
      cyc_begin();
      check("miss_ren_hold", {31'b0, ICACHE_ren}, 1);
      check("miss_addr_hold", {2'b0, ICACHE_addr}, 32'h60);
      check("miss_no_stale", {31'b0, inst_valid}, 0);
      cyc_end();
    end
    cyc_begin();
    check("miss_new_addr", {2'b0, ICACHE_addr}, 32'h80);
    check("miss_new_ren", {31'b0, ICACHE_ren}, 1);
    check("miss_no_stale2", {31'b0, inst_valid}, 0);
    cyc_end();
    cyc_begin();
    check("miss_valid", {31'b0, inst_valid}, 1);
    check("miss_pc", inst_pc, 32'h200);
    cyc_end();

    // ---- reset with 6 entries queued ----
    ready_pct = 0;
    step(1'b0, 1'b1, 32'h240);
    repeat (3) step();
    cyc_begin(1'b1);
    check("rmid_ren", {31'b0, ICACHE_ren}, 0);
    cyc_end();
    stall_pct = 100;
    cyc_begin();
    check("rmid_valid", {31'b0, inst_valid}, 0);
    check("rmid_ren_on", {31'b0, ICACHE_ren}, 1);
    cyc_end();
    cyc_begin();
    check("rmid_addr", {2'b0, ICACHE_addr}, {2'b0, RESET_PC[31:2]});
    check("rmid_valid2", {31'b0, inst_valid}, 0);
    cyc_end();
    stall_pct = 0;
    ready_pct = 100;

    // ---- randomized run ----
    d0 = n_deq;
    for (int i = 0; i < 3000; i++) begin
      bit          r, rd;
      logic [31:0] rpc;
      if (i % 500 == 0) begin
        case ($urandom_range(2))
          0:       stall_pct = 0;
          1:       stall_pct = 30;
          default: stall_pct = 70;
        endcase
        ready_pct = 50 + int'($urandom_range(50));
      end
      r   = ($urandom_range(199) == 0);
      rd  = ($urandom_range(24) == 0);
      rpc = $urandom_range(32'h1FFF);
      step(r, rd, rpc);
    end
    cyc_begin();
    check("rand_progress", {31'b0, (n_deq - d0) > 500}, 1);
    check("tie_wen", {31'b0, ICACHE_wen}, 0);
    check("tie_wdata", ICACHE_wdata, 0);
    cyc_end();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
